// File: rtl/arm_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pipe_pkg
//  Description : Shared constants and types for the 5-stage ARM pipeline
//                hazard tracking logic (register index width, register count,
//                in-flight counter width and its saturation value).
//  Revision    : 1.0  initial release
// ============================================================================
package arm_pipe_pkg;

    localparam int REG_W    = 4;
    localparam int NUM_REGS = 16;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef logic [REG_W-1:0] reg_idx_t;

endpackage : arm_pipe_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_entry.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_entry
//  Description : One saturating up/down in-flight writer counter.
//                Ports: clk, rst (async, active-low), i_inc / i_dec (issue and
//                retire events for this register), o_cnt (current count),
//                o_err (single-cycle pulse on overflow or underflow attempt).
//  Revision    : 1.0  initial release
// ============================================================================
module scoreboard_entry #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_err
);

    localparam logic [W-1:0] c_cnt_max = '1;

    logic [W-1:0] r_cnt;
    logic         w_up;
    logic         w_down;

    // Simultaneous issue and retire cancel out and cannot be an error.
    assign w_up   = i_inc & ~i_dec;
    assign w_down = i_dec & ~i_inc;

    assign o_err = (w_up & (r_cnt == c_cnt_max)) | (w_down & (r_cnt == '0));
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_up && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_down && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule : scoreboard_entry
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Issue-side hazard tracker. Counts in-flight writers per
//                architectural register, retires them at write-back and
//                raises the ID-stage stall when a source cannot be forwarded.
//  Ports       : clk, rst (async, active-low)
//                issue_valid/issue_wb_en/issue_dest/issue_is_load  - EXE entry
//                src_valid/src_1/src_2/two_src                     - ID sources
//                wb_valid/wb_dest                                  - WB retire
//                stall, pending[NUM_REGS], err (sticky)            - outputs
//  Config      : FORWARDING_EN defined   -> only load-use stalls (load tracker)
//                FORWARDING_EN undefined -> stall on any pending source
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic                            issue_wb_en,
    input  logic [arm_pipe_pkg::REG_W-1:0]  issue_dest,
    input  logic                            issue_is_load,
    input  logic                            src_valid,
    input  logic [arm_pipe_pkg::REG_W-1:0]  src_1,
    input  logic [arm_pipe_pkg::REG_W-1:0]  src_2,
    input  logic                            two_src,
    input  logic                            wb_valid,
    input  logic [arm_pipe_pkg::REG_W-1:0]  wb_dest,
    output logic                            stall,
    output logic [NUM_REGS-1:0]             pending,
    output logic                            err
);

    logic                w_issue;
    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_ent_err;
    logic [NUM_REGS-1:0] w_hit;
    logic [NUM_REGS-1:0] w_retire;
    logic                r_err;

    assign w_issue = issue_valid & issue_wb_en;

`ifndef FORWARDING_EN
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    logic [NUM_REGS-1:0] w_block;
`endif

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
            localparam arm_pipe_pkg::reg_idx_t c_idx = arm_pipe_pkg::reg_idx_t'(g);

            assign w_retire[g] = wb_valid & (wb_dest == c_idx);
            assign w_hit[g]    = src_valid & ((src_1 == c_idx) | (two_src & (src_2 == c_idx)));

            scoreboard_entry #(
                .W (CNT_W)
            ) u_entry (
                .clk   (clk),
                .rst   (rst),
                .i_inc (w_issue & (issue_dest == c_idx)),
                .i_dec (w_retire[g]),
                .o_cnt (w_cnt[g]),
                .o_err (w_ent_err[g])
            );

            assign pending[g] = (w_cnt[g] != '0);

`ifndef FORWARDING_EN
            // The register file writes on the falling edge, so the last
            // writer retiring this cycle already satisfies the ID read.
            assign w_block[g] = pending[g] & w_hit[g] &
                                ~(w_retire[g] & (w_cnt[g] == c_cnt_one));
`endif
        end
    endgenerate

`ifdef FORWARDING_EN
    // Tracks the load sitting in EXE; it is there for exactly one cycle, so
    // the load-use stall lasts exactly one cycle once the bubble is injected.
    logic                    r_ld_exe_v;
    arm_pipe_pkg::reg_idx_t  r_ld_exe_dest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_exe_v    <= 1'b0;
            r_ld_exe_dest <= '0;
        end else begin
            r_ld_exe_v    <= w_issue & issue_is_load;
            r_ld_exe_dest <= issue_dest;
        end
    end

    assign stall = r_ld_exe_v & w_hit[r_ld_exe_dest];
`else
    logic w_unused_load;
    assign w_unused_load = issue_is_load;
    assign stall         = |w_block;
`endif

    // Issuing while stalled breaks the controller contract and is flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((|w_ent_err) || (issue_valid && stall)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NR   = 16;
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wb_en, issue_is_load;
    logic [3:0]  issue_dest;
    logic        src_valid, two_src;
    logic [3:0]  src_1, src_2;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic        stall;
    logic [15:0] pending;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    int          m_cnt [NR];
    bit          m_err;
    bit          m_ld_v;
    logic [3:0]  m_ld_dest;

    hazard_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_dest(issue_dest), .issue_is_load(issue_is_load),
        .src_valid(src_valid), .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .wb_valid(wb_valid), .wb_dest(wb_dest),
        .stall(stall), .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit reads(input logic [3:0] r);
        return src_valid && (src_1 == r || (two_src && src_2 == r));
    endfunction

    function automatic bit model_stall();
        bit s = 0;
`ifdef FORWARDING_EN
        s = m_ld_v && reads(m_ld_dest);
`else
        for (int r = 0; r < NR; r++) begin
            bool_check: begin
                bit retiring_last = wb_valid && (wb_dest == 4'(r)) && (m_cnt[r] == 1);
                if (m_cnt[r] > 0 && !retiring_last && reads(4'(r))) s = 1;
            end
        end
`endif
        return s;
    endfunction

    function automatic logic [15:0] model_pending();
        logic [15:0] p = '0;
        for (int r = 0; r < NR; r++) p[r] = (m_cnt[r] > 0);
        return p;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_err = 0; m_ld_v = 0; m_ld_dest = '0;
    endtask

    task automatic idle();
        issue_valid = 0; issue_wb_en = 0; issue_dest = '0; issue_is_load = 0;
        src_valid = 0; src_1 = '0; src_2 = '0; two_src = 0;
        wb_valid = 0; wb_dest = '0;
    endtask

    // One clock: model advances with the inputs held across the edge.
    task automatic tick();
        bit st = model_stall();
        @(posedge clk);
        for (int r = 0; r < NR; r++) begin
            int d = 0;
            if (issue_valid && issue_wb_en && issue_dest == 4'(r)) d++;
            if (wb_valid && wb_dest == 4'(r)) d--;
            if (d > 0) begin
                if (m_cnt[r] == CMAX) m_err = 1; else m_cnt[r]++;
            end else if (d < 0) begin
                if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
            end
        end
        if (issue_valid && st) m_err = 1;
        m_ld_v    = issue_valid && issue_wb_en && issue_is_load;
        m_ld_dest = issue_dest;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        model_clear();
        #1;
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        model_clear();
        #3;
        n_vec++; if (pending !== 16'h0) begin n_bad++; $display("FAIL reset_pending got=%h exp=%h", pending, 16'h0); end
        n_vec++; if (stall !== 1'b0)    begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_vec++; if (err !== 1'b0)      begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_forward_add();
        do_reset();
        issue_valid = 1; issue_wb_en = 1; issue_dest = 4'd3;
        #1; tick();
        idle(); src_valid = 1; src_1 = 4'd3; src_2 = 4'd0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fwd_add_stall got=%b exp=0", stall); end
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (pending[3] !== 1'b1) begin n_bad++; $display("FAIL fwd_add_pending c=%0d got=%b exp=1", c, pending[3]); end
            tick();
            src_valid = 0;
        end
        wb_valid = 1; wb_dest = 4'd3;
        #1; tick(); idle(); #1;
        n_vec++; if (pending[3] !== 1'b0) begin n_bad++; $display("FAIL fwd_add_retire got=%b exp=0", pending[3]); end
    endtask

    task automatic test_stall_until_wb();
        do_reset();
        issue_valid = 1; issue_wb_en = 1; issue_dest = 4'd7;
        #1; tick();
        idle(); src_valid = 1; src_1 = 4'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL wb_wait_stall c=%0d got=%b exp=1", c, stall); end
            tick();
        end
        wb_valid = 1; wb_dest = 4'd7;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL wb_same_cycle_stall got=%b exp=0", stall); end
        tick();
        wb_valid = 0;
        #1;
        n_vec++; if (pending !== 16'h0 || stall !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL wb_after got pend=%h stall=%b err=%b exp 0/0/0", pending, stall, err);
        end
    endtask

    task automatic test_load_use();
        logic exp_after;
`ifdef FORWARDING_EN
        exp_after = 1'b0;
`else
        exp_after = 1'b1;
`endif
        do_reset();
        issue_valid = 1; issue_wb_en = 1; issue_is_load = 1; issue_dest = 4'd5;
        #1; tick();
        idle(); src_valid = 1; src_1 = 4'd0; src_2 = 4'd5; two_src = 0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_use_one_src got=%b exp=0", stall); end
        two_src = 1;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ld_use_stall got=%b exp=1", stall); end
        tick();
        #1;
        n_vec++; if (stall !== exp_after) begin n_bad++; $display("FAIL ld_use_after_bubble got=%b exp=%b", stall, exp_after); end
        wb_valid = 1; wb_dest = 4'd5;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_use_retire got=%b exp=0", stall); end
        tick(); idle(); #1;
        n_vec++; if (pending[5] !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL ld_use_clean got pend5=%b err=%b exp 0/0", pending[5], err);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue_valid = 1; issue_wb_en = 1; issue_dest = 4'd2;
        #1; tick();
        wb_valid = 1; wb_dest = 4'd2;
        #1; tick();
        idle(); #1;
        n_vec++; if (pending[2] !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle_hold got pend2=%b err=%b exp 1/0", pending[2], err);
        end
        wb_valid = 1; wb_dest = 4'd2;
        #1; tick(); idle(); #1;
        n_vec++; if (pending[2] !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle_one_retire got pend2=%b err=%b exp 0/0", pending[2], err);
        end
        wb_valid = 1; wb_dest = 4'd2;
        #1; tick(); idle(); #1;
        n_vec++; if (err !== 1'b1 || pending[2] !== 1'b0) begin
            n_bad++; $display("FAIL underflow got err=%b pend2=%b exp 1/0", err, pending[2]);
        end
        tick(); tick();
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_saturate();
        do_reset();
        issue_valid = 1; issue_wb_en = 1; issue_dest = 4'd9;
        for (int c = 0; c < 3; c++) begin #1; tick(); end
        n_vec++; if (err !== 1'b0 || pending[9] !== 1'b1) begin
            n_bad++; $display("FAIL sat_pre got err=%b pend9=%b exp 0/1", err, pending[9]);
        end
        #1; tick();
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL sat_err got=%b exp=1", err); end
        idle(); wb_valid = 1; wb_dest = 4'd9;
        for (int c = 0; c < 2; c++) begin #1; tick(); end
        n_vec++; if (pending[9] !== 1'b1) begin n_bad++; $display("FAIL sat_two_retired got=%b exp=1", pending[9]); end
        #1; tick(); idle(); #1;
        n_vec++; if (pending[9] !== 1'b0) begin n_bad++; $display("FAIL sat_value got pend9=%b exp=0", pending[9]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_valid = 1; issue_wb_en = 1;
        issue_dest = 4'd1; #1; tick();
        issue_dest = 4'd4; #1; tick();
        issue_dest = 4'd6; #1; tick();
        idle(); src_valid = 1; src_1 = 4'd4; #1;
        n_vec++; if (pending !== 16'h0052) begin n_bad++; $display("FAIL async_pre got=%h exp=%h", pending, 16'h0052); end
        #1;
        rst = 0;
        model_clear();
        #1;
        n_vec++; if (pending !== 16'h0 || stall !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL async_clear got pend=%h stall=%b err=%b exp 0/0/0", pending, stall, err);
        end
        idle();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit exp_st;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r;
            issue_valid   = ($urandom_range(0, 2) != 0);
            issue_wb_en   = $urandom_range(0, 1);
            issue_dest    = 4'($urandom_range(0, 15));
            issue_is_load = $urandom_range(0, 1);
            src_valid     = $urandom_range(0, 3) != 0;
            src_1         = 4'($urandom_range(0, 15));
            src_2         = 4'($urandom_range(0, 15));
            two_src       = $urandom_range(0, 1);
            r             = $urandom_range(0, 15);
            wb_dest       = 4'(r);
            wb_valid      = (m_cnt[r] > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
            #1;
            exp_st = model_stall();
            if (issue_valid && exp_st && $urandom_range(0, 15) != 0) issue_valid = 0;
            #1;
            n_vec++; if (stall !== exp_st) begin n_bad++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, stall, exp_st); end
            tick();
            n_vec++; if (pending !== model_pending()) begin
                n_bad++; $display("FAIL rnd_pending i=%0d got=%h exp=%h", i, pending, model_pending());
            end
            n_vec++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, err, m_err); end
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
        end
        idle();
    endtask

    initial begin
        test_reset();
`ifdef FORWARDING_EN
        test_forward_add();
`else
        test_stall_until_wb();
`endif
        test_load_use();
        test_same_cycle();
        test_saturate();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side hazard tracker for the 5-stage ARM pipeline; the producer-side counterpart of the ID-stage forwarding select logic. Records the destination of every register-writing instruction entering EXE, retires it at write-back, and drives the ID-stage `stall` when a source operand cannot be satisfied by forwarding. Sits beside the ID/EXE pipeline register; `stall` freezes IF/ID and injects a bubble into EXE.

## Interface
Parameters:
- `NUM_REGS`, 16: architectural registers tracked (R0–R15).
- `CNT_W`, 2: width of each in-flight counter; max count 2^CNT_W−1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: instruction enters EXE this cycle.
- `issue_wb_en` in 1: issuing instruction writes a register.
- `issue_dest` in 4: issuing instruction's destination.
- `issue_is_load` in 1: issuing instruction is LDR.
- `src_valid` in 1: ID holds a valid instruction.
- `src_1` in 4: first source register (Rn).
- `src_2` in 4: second source register (Rm/Rd for STR).
- `two_src` in 1: `src_2` is read.
- `wb_valid` in 1: WB stage writes the register file this cycle.
- `wb_dest` in 4: WB destination.
- `stall` out 1: hold IF/ID, bubble into EXE.
- `pending` out NUM_REGS: bit r = register r has ≥1 in-flight writer.
- `err` out 1: sticky protocol error.

## Operation
- Per-register counter `cnt[r]`. Issue event = `issue_valid & issue_wb_en`; retire event = `wb_valid`.
- Per cycle for each r: +1 if issue targets r, −1 if retire targets r; both → unchanged.
- Increment at max → counter saturates, `err` set. Retire with `cnt[r]==0` → counter stays 0, `err` set.
- `pending[r] = (cnt[r] != 0)`, from registered state only.
- Load tracker: `ld_exe_v`/`ld_exe_dest` capture `issue_valid & issue_wb_en & issue_is_load` and `issue_dest` every cycle; cleared when no load issues. Models the load currently in EXE.
- `hit(s)` = `src_valid & (s==src_1 | (two_src & s==src_2))`.
- Stall rule per configuration (below); `stall` is combinational from state and ID inputs.
- Controller contract: `issue_valid` is 0 in any cycle where `stall` is 1. Issue during stall is counted normally but sets `err`.
- `err` clears only on reset.

## Timing
- Reset (async, `rst`=0): all counters 0, `ld_exe_v`=0, `err`=0; hence `pending`=0, `stall`=0.
- Counter update and load capture: visible in the cycle after the issue/retire edge.
- `stall`: zero-latency combinational in the same cycle as `src_*`.
- The register file writes on the falling edge, so a retire this cycle satisfies a same-cycle read: a register with `cnt==1` and matching `wb_valid/wb_dest` is treated as not pending for `stall`.
- A load-use hazard costs exactly one stall cycle: the load moves to MEM and `ld_exe_v` drops in the next cycle.
- Reset asserted mid-operation discards all in-flight state immediately.

## Configuration
- `FORWARDING_EN` defined: `stall = ld_exe_v & hit(ld_exe_dest)`. Only load-use stalls; MEM/WB forwarding covers everything else.
- `FORWARDING_EN` undefined: `stall = hit(r)` for any r with `pending[r]` that is not retiring this cycle. The load tracker is not synthesised.
- Counters, `pending` and `err` are identical in both builds.

## Structure
- Shared package `arm_pipe_pkg` holds `REG_W`=4, `NUM_REGS`=16, `CNT_W`, `CNT_MAX`, and the `reg_idx_t` typedef.
- Sub-module `scoreboard_entry` holds one saturating up/down counter with inc/dec/err outputs. It is instantiated NUM_REGS times via generate.
- The top level holds the decode, the load tracker and the stall mux.

## Test plan
- Reset with all inputs idle → `pending`=0, `stall`=0, `err`=0; drop `rst` mid-run with 3 writers pending → all clear asynchronously.
- Issue ADD R3, then SUB reading R3 in the next cycle (FORWARDING_EN) → `stall`=0, `pending[3]`=1 for 3 cycles, retire at WB → `pending[3]`=0.
- Issue LDR R5, ID reads R5 via `src_2` with `two_src`=1 in the next cycle → `stall`=1 for exactly 1 cycle; the same access with `two_src`=0 → `stall`=0.
- Without FORWARDING_EN, issue R7 writer, ID reads R7 → `stall`=1 until the cycle where `wb_valid`,`wb_dest`=7 → `stall`=0 in that cycle.
- Issue and retire R2 in the same cycle with `cnt[2]`=1 → `cnt[2]` stays 1; a lone retire with `cnt[2]`=0 → `err`=1 and stays 1.
- 4 back-to-back issues to R9 with no retire (CNT_W=2) → counter saturates at 3, `err`=1.
